// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// Forwarding is compiled in only when ID_EX_FORWARD_EN is defined; otherwise operands come straight from the stored register-file data.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_func,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_aluout,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_wdata,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_func,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_valid,
    output logic              load_use_hazard
);

    // ex_valid marks a real instruction in EX; it is 0 for a bubble. There is no
    // ready input: stall holds the register, flush replaces its contents with a bubble.
    logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm;
    logic [REG_AW-1:0] r_rs, r_rt, r_rd;
    logic [3:0]        r_func;
    logic              r_alusrc, r_regdst, r_regwrite, r_memread, r_memwrite, r_memtoreg, r_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_func     <= 4'b0000;
            r_alusrc   <= 1'b0;
            r_regdst   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_valid    <= 1'b0;
        end else if (!stall) begin
            r_rs_data  <= id_rs_data;
            r_rt_data  <= id_rt_data;
            r_imm      <= id_imm;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rd       <= id_rd;
            r_func     <= id_func;
            r_alusrc   <= id_alusrc;
            r_regdst   <= id_regdst;
            r_regwrite <= id_regwrite;
            r_memread  <= id_memread;
            r_memwrite <= id_memwrite;
            r_memtoreg <= id_memtoreg;
            r_valid    <= 1'b1;
        end
    end

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] rt_fwd;

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger result and wins over MEM/WB; register 0 is never forwarded.
    always_comb begin
        op_a = r_rs_data;
        if (exmem_regwrite && (exmem_rd == r_rs) && (r_rs != '0))
            op_a = exmem_aluout;
        else if (memwb_regwrite && (memwb_rd == r_rs) && (r_rs != '0))
            op_a = memwb_wdata;
    end

    always_comb begin
        rt_fwd = r_rt_data;
        if (exmem_regwrite && (exmem_rd == r_rt) && (r_rt != '0))
            rt_fwd = exmem_aluout;
        else if (memwb_regwrite && (memwb_rd == r_rt) && (r_rt != '0))
            rt_fwd = memwb_wdata;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_aluout,
                          memwb_regwrite, memwb_rd, memwb_wdata};
    assign op_a   = r_rs_data;
    assign rt_fwd = r_rt_data;
`endif

    assign alu_in1       = op_a;
    assign alu_in2       = r_alusrc ? r_imm : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign alu_func      = r_func;
    assign ex_wreg       = r_regdst ? r_rd : r_rt;
    assign ex_regwrite   = r_regwrite;
    assign ex_memread    = r_memread;
    assign ex_memwrite   = r_memwrite;
    assign ex_memtoreg   = r_memtoreg;
    assign ex_valid      = r_valid;

    // A load in EX whose destination is read by the instruction now in ID.
    assign load_use_hazard = r_valid && r_memread && (ex_wreg != '0) &&
                             ((ex_wreg == id_rs) || (ex_wreg == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: the driver pushes expected output words into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int W = 3 * DATA_W + 4 + REG_AW + 6;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, stall, flush;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic [3:0] id_func;
    logic id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic exmem_regwrite, memwb_regwrite;
    logic [REG_AW-1:0] exmem_rd, memwb_rd;
    logic [DATA_W-1:0] exmem_aluout, memwb_wdata;
    logic [DATA_W-1:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0] alu_func;
    logic [REG_AW-1:0] ex_wreg;
    logic ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_valid, load_use_hazard;

    logic [W-1:0] exp_q[$];
    string name_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_func(id_func),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_aluout(exmem_aluout),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_func(alu_func),
        .ex_store_data(ex_store_data), .ex_wreg(ex_wreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_valid(ex_valid), .load_use_hazard(load_use_hazard)
    );

    // clock / reset
    always #5 clk = ~clk;

    logic [W-1:0] got;
    assign got = {alu_in1, alu_in2, ex_store_data, alu_func, ex_wreg,
                  ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_valid, load_use_hazard};

    function automatic logic [W-1:0] mk(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                        input logic [DATA_W-1:0] s, input logic [3:0] f,
                                        input logic [REG_AW-1:0] wr, input logic rw, input logic mr,
                                        input logic mw, input logic mt, input logic v, input logic h);
        return {a, b, s, f, wr, rw, mr, mw, mt, v, h};
    endfunction

    // driver tasks
    task automatic clear_in();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_func = 4'b0000;
        id_alusrc = 1'b0; id_regdst = 1'b0; id_regwrite = 1'b0;
        id_memread = 1'b0; id_memwrite = 1'b0; id_memtoreg = 1'b0;
        exmem_regwrite = 1'b0; exmem_rd = '0; exmem_aluout = '0;
        memwb_regwrite = 1'b0; memwb_rd = '0; memwb_wdata = '0;
    endtask

    task automatic slot();
        @(negedge clk); #1;
        clear_in();
    endtask

    task automatic edge_pass();
        @(posedge clk); #1;
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h (in1 in2 store func wreg rw mr mw mt v haz)", nm, got, e);
            end
        end
    end

    initial begin
        clear_in();

        slot(); rst = 1'b1;
        exmem_regwrite = 1'b1; exmem_aluout = 32'd7; memwb_regwrite = 1'b1; memwb_wdata = 32'd9;
        edge_pass();
        expect_out("reset", mk('0, '0, '0, 4'b0000, '0, 0, 0, 0, 0, 0, 0));

        slot(); id_rs_data = 32'd2; id_rt_data = 32'd1; id_func = 4'b0010;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_regdst = 1'b1; id_regwrite = 1'b1;
        edge_pass();
        expect_out("add_basic", mk(32'd2, 32'd1, 32'd1, 4'b0010, 5'd3, 1, 0, 0, 0, 1, 0));

        slot(); id_rs = 5'd3; id_rs_data = 32'h11; id_rt = 5'd5; id_rt_data = 32'h22;
        id_func = 4'b0110; id_regwrite = 1'b1;
        exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_aluout = 32'hFFFFFFFF;
        memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_wdata = 32'd5;
        edge_pass();
        expect_out("fwd_exmem_rs", mk(FWD ? 32'hFFFFFFFF : 32'h11, 32'h22, 32'h22, 4'b0110, 5'd5, 1, 0, 0, 0, 1, 0));

        slot(); stall = 1'b1; id_rs_data = 32'hDEAD; id_func = 4'b1111; id_rd = 5'd9;
        memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_wdata = 32'd5;
        edge_pass();
        expect_out("stall_fwd_memwb_rs", mk(FWD ? 32'd5 : 32'h11, 32'h22, 32'h22, 4'b0110, 5'd5, 1, 0, 0, 0, 1, 0));

        slot(); stall = 1'b1;
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_aluout = 32'h77;
        memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_wdata = 32'h99;
        edge_pass();
        expect_out("stall_fwd_rt", mk(32'h11, FWD ? 32'h77 : 32'h22, FWD ? 32'h77 : 32'h22, 4'b0110, 5'd5, 1, 0, 0, 0, 1, 0));

        slot(); id_rs_data = 32'hAB; id_rt_data = 32'hCD; id_rd = 5'd2; id_regdst = 1'b1; id_regwrite = 1'b1;
        exmem_regwrite = 1'b1; exmem_aluout = 32'd7; memwb_regwrite = 1'b1; memwb_wdata = 32'd9;
        edge_pass();
        expect_out("no_fwd_r0", mk(32'hAB, 32'hCD, 32'hCD, 4'b0000, 5'd2, 1, 0, 0, 0, 1, 0));

        slot(); id_rs = 5'd7; id_rs_data = 32'h10; id_rt = 5'd6; id_rt_data = 32'h1234;
        id_imm = 32'h0000FFFF; id_alusrc = 1'b1; id_func = 4'b0101; id_regwrite = 1'b1;
        exmem_regwrite = 1'b1; exmem_rd = 5'd6; exmem_aluout = 32'h5555;
        edge_pass();
        expect_out("lui_imm", mk(32'h10, 32'h0000FFFF, FWD ? 32'h5555 : 32'h1234, 4'b0101, 5'd6, 1, 0, 0, 0, 1, 0));

        slot(); id_rs = 5'd1; id_rs_data = 32'h100; id_rt = 5'd4; id_rt_data = 32'h44; id_rd = 5'd9;
        id_imm = 32'd8; id_alusrc = 1'b1; id_func = 4'b0010;
        id_memread = 1'b1; id_regwrite = 1'b1; id_memtoreg = 1'b1;
        edge_pass();
        id_rs = 5'd4; id_rt = 5'd0;
        expect_out("load_use_rs", mk(32'h100, 32'd8, 32'h44, 4'b0010, 5'd4, 1, 1, 0, 1, 1, 1));

        slot(); stall = 1'b1; id_rs = 5'd2; id_rt = 5'd4; id_rs_data = 32'hDEAD; id_func = 4'b1111;
        edge_pass();
        expect_out("load_use_rt_hold", mk(32'h100, 32'd8, 32'h44, 4'b0010, 5'd4, 1, 1, 0, 1, 1, 1));

        slot(); stall = 1'b1; id_rs = 5'd2; id_rt = 5'd3;
        edge_pass();
        expect_out("no_hazard_hold", mk(32'h100, 32'd8, 32'h44, 4'b0010, 5'd4, 1, 1, 0, 1, 1, 0));

        slot(); stall = 1'b1; flush = 1'b1; id_rs = 5'd4; id_rt = 5'd4; id_rs_data = 32'h3;
        id_memread = 1'b1; id_regwrite = 1'b1; id_func = 4'b1011;
        edge_pass();
        expect_out("flush_over_stall", mk('0, '0, '0, 4'b0000, '0, 0, 0, 0, 0, 0, 0));

        slot(); id_rs = 5'd2; id_rs_data = 32'h200; id_rt = 5'd3; id_rt_data = 32'h333;
        id_imm = 32'd4; id_alusrc = 1'b1; id_func = 4'b0010; id_memwrite = 1'b1;
        edge_pass();
        expect_out("store", mk(32'h200, 32'd4, 32'h333, 4'b0010, 5'd3, 0, 0, 1, 0, 1, 0));

        slot(); rst = 1'b1; stall = 1'b1; id_rs_data = 32'h55; id_regwrite = 1'b1; id_func = 4'b1110;
        edge_pass();
        expect_out("reset_mid_stall", mk('0, '0, '0, 4'b0000, '0, 0, 0, 0, 0, 0, 0));

        slot(); id_rs = 5'd1; id_rs_data = 32'd5; id_rt_data = 32'h66; id_alusrc = 1'b1;
        id_func = 4'b0010; id_memread = 1'b1; id_regwrite = 1'b1; id_memtoreg = 1'b1;
        edge_pass();
        id_rs = 5'd0; id_rt = 5'd0;
        expect_out("load_r0_no_hazard", mk(32'd5, 32'd0, 32'h66, 4'b0010, 5'd0, 1, 1, 0, 1, 1, 0));

        slot(); flush = 1'b1; id_rs_data = 32'h8; id_regwrite = 1'b1; id_func = 4'b1010;
        edge_pass();
        expect_out("flush_only", mk('0, '0, '0, 4'b0000, '0, 0, 0, 0, 0, 0, 0));

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
